wb_lsu_master: RTL

Wishbone initiator that turns single CPU load/store requests into one classic Wishbone cycle each, toward the byte-addressed data memory responder on the same bus. It checks alignment and address range, forwards `funct3` so the responder does byte/half/word selection and sign extension, and waits for `ack` with a timeout. It returns one response per request and guards against the responder's registered, level-held `ack`.

---
 rtl/wb_lsu_pkg.sv | 38 +++
 rtl/wb_lsu_if.sv | 43 ++++
 rtl/wb_timeout_ctr.sv | 41 ++++
 rtl/wb_lsu_master.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/wb_lsu_pkg.sv
// Shared types and constants for the Wishbone load/store initiator:
// FSM states, response cause codes, RISC-V funct3 encodings and the alignment rule.
package wb_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_BUS     = 2'b01,
        ST_RECOVER = 2'b10
    } lsu_state_e;

    typedef enum logic [1:0] {
        CAUSE_OK       = 2'b00,
        CAUSE_MISALIGN = 2'b01,
        CAUSE_RANGE    = 2'b10,
        CAUSE_TIMEOUT  = 2'b11
    } cause_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access size lives in funct3[1:0]; sign bit funct3[2] does not affect alignment.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        case (funct3[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/wb_lsu_if.sv
// CPU request/response handshake plus Wishbone initiator signals, bundled
// with modports for the LSU (master) and the environment side (slave).
interface wb_lsu_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [31:0]           req_addr;
    logic [2:0]            req_funct3;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;
    logic [1:0]            resp_cause;

    logic                  wb_cyc_o;
    logic                  wb_stb_o;
    logic                  wb_we_o;
    logic [ADDR_WIDTH-1:0] wb_adr_o;
    logic [DATA_WIDTH-1:0] wb_dat_o;
    logic [2:0]            wb_funct3_o;
    logic [DATA_WIDTH-1:0] wb_dat_i;
    logic                  wb_ack_i;

    modport master (
        input  req_valid, req_we, req_addr, req_funct3, req_wdata,
        input  wb_dat_i, wb_ack_i,
        output req_ready, resp_valid, resp_rdata, resp_err, resp_cause,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_funct3_o
    );

    modport slave (
        output req_valid, req_we, req_addr, req_funct3, req_wdata,
        output wb_dat_i, wb_ack_i,
        input  req_ready, resp_valid, resp_rdata, resp_err, resp_cause,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_funct3_o
    );

endinterface

// File: rtl/wb_timeout_ctr.sv
// Saturating cycle counter; expired is high during the TIMEOUT-th enabled
// cycle after a clear, so the caller can abort on that same edge.
module wb_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count up while enabled and not yet at LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/wb_lsu_master.sv
// Wishbone initiator: one classic cycle per accepted load/store, with alignment,
// range and ack-timeout checking, and a RECOVER state that waits out a held ack.
module wb_lsu_master #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic     clk,
    input  logic     rst_n,
    wb_lsu_if.master bus
);

    import wb_lsu_pkg::*;

    lsu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [2:0]            funct3_q, funct3_d;
    logic                  we_q, we_d;
    logic                  cyc_q, cyc_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    cause_e                cause_q, cause_d;
    cause_e                req_cause_s;
    logic                  range_ok_s;
    logic                  ctr_clear_s;
    logic                  ctr_en_s;
    logic                  expired_s;

    wb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (ctr_clear_s),
        .enable  (ctr_en_s),
        .expired (expired_s)
    );

    assign range_ok_s = ((bus.req_addr >> ADDR_WIDTH) == 32'd0);

    // Classify the incoming request; misalignment takes priority over range.
    always_comb begin
        req_cause_s = CAUSE_OK;
        if (is_misaligned(bus.req_funct3, bus.req_addr[1:0])) begin
            req_cause_s = CAUSE_MISALIGN;
        end else if (!range_ok_s) begin
            req_cause_s = CAUSE_RANGE;
        end else begin
            req_cause_s = CAUSE_OK;
        end
    end

    // FSM next state, bus request registers and the one-cycle response pulse.
    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        cyc_d       = cyc_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        cause_d     = CAUSE_OK;
        rdata_d     = '0;
        ctr_clear_s = 1'b0;
        ctr_en_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (req_cause_s != CAUSE_OK) begin
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                        cause_d = req_cause_s;
                    end else begin
                        adr_d       = bus.req_addr[ADDR_WIDTH-1:0];
                        dat_d       = bus.req_wdata;
                        we_d        = bus.req_we;
                        funct3_d    = bus.req_funct3;
                        cyc_d       = 1'b1;
                        ctr_clear_s = 1'b1;
                        state_d     = ST_BUS;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS: begin
                ctr_en_s = 1'b1;
                // An ack on the expiry cycle still counts as success.
                if (bus.wb_ack_i) begin
                    valid_d = 1'b1;
                    rdata_d = we_q ? '0 : bus.wb_dat_i;
                    cyc_d   = 1'b0;
                    state_d = ST_RECOVER;
                end else if (expired_s) begin
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                    cyc_d   = 1'b0;
                    state_d = ST_RECOVER;
                end else begin
                    state_d = ST_BUS;
                end
            end
            ST_RECOVER: begin
                if (!bus.wb_ack_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RECOVER;
                end
            end
            default: begin
                cyc_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            adr_q    <= '0;
            dat_q    <= '0;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            cyc_q    <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            cause_q  <= CAUSE_OK;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            cyc_q    <= cyc_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            cause_q  <= cause_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.req_ready   = (state_q == ST_IDLE);
    assign bus.resp_valid  = valid_q;
    assign bus.resp_rdata  = rdata_q;
    assign bus.resp_err    = err_q;
    assign bus.resp_cause  = cause_q;
    assign bus.wb_cyc_o    = cyc_q;
    assign bus.wb_stb_o    = cyc_q;
    assign bus.wb_we_o     = we_q;
    assign bus.wb_adr_o    = adr_q;
    assign bus.wb_dat_o    = dat_q;
    assign bus.wb_funct3_o = funct3_q;

endmodule
